// File: rtl/kmc_npr_arb_pkg.sv
// kmc_npr_arb_pkg: shared types and constants for the KMC11 NPR arbiter.
// Build option: KMCNPRARB_RR_EN selects round-robin (default fixed priority).
package kmc_npr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } nprState_t;

  // Default hold limit, in cycles after acknowledge.
  localparam int HOLDMAX_DEF = 1024;

  // Width of the hold counter.
  localparam int CNT_W = 12;

endpackage

// File: rtl/kmc_npr_rrpick.sv
// kmc_npr_rrpick: rotate-then-priority-encode picker. The search starts at
// ptr and wraps upward; the first asserted request wins. With ptr tied to 0
// it degenerates to a fixed lowest-index-wins encoder.
// Build option: none here (KMCNPRARB_RR_EN is handled by the top).
module kmc_npr_rrpick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  int          cand;
  logic [IW-1:0] candIdx;

  // Walk offsets from farthest to nearest so the nearest asserted one sticks.
  always_comb begin
    idx     = '0;
    valid   = |req;
    cand    = 0;
    candIdx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      candIdx = IW'(cand);
      if (req[candIdx]) idx = candIdx;
    end
  end

endmodule

// File: rtl/kmc_npr_arb.sv
// kmc_npr_arb: shares the single KS10 backplane NPR master port among NREQ
// device-side requesters. One winner at a time gets a single upstream bus
// request, a one-cycle ack, and then holds the grant until it releases or
// the hold timer forces it out.
// Build option: define KMCNPRARB_RR_EN for round-robin selection; otherwise
// fixed priority (lowest index wins) and no rotate pointer is built.
module kmc_npr_arb
  import kmc_npr_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int HOLDMAX = HOLDMAX_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           reqI,
  output logic [NREQ-1:0]           ackO,
  output logic                      busREQO,
  input  logic                      busACKI,
  output logic [$clog2(NREQ)-1:0]   grantIDX,
  output logic                      busyO,
  output logic                      errO
);

  localparam int IW = $clog2(NREQ);

  nprState_t         state, stateN;
  logic [CNT_W-1:0]  cnt, cntN;
  logic [IW-1:0]     grantN;
  logic [NREQ-1:0]   ackN;
  logic              busReqN;
  logic              errN;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     pickIdx;
  logic              pickValid;
  logic              winnerReq;
  logic              grantTaken;

  assign winnerReq  = reqI[grantIDX];
  // The single event that advances the rotate pointer: a real grant.
  assign grantTaken = (state == REQ) && winnerReq && busACKI;

`ifdef KMCNPRARB_RR_EN
  // Rotate pointer: next search starts just past the last acknowledged winner.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (grantTaken)
      ptr <= (grantIDX == IW'(NREQ - 1)) ? '0 : grantIDX + 1'b1;
  end
`else
  assign ptr = '0;
`endif

  kmc_npr_rrpick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) uPick (
    .req   (reqI),
    .ptr   (ptr),
    .idx   (pickIdx),
    .valid (pickValid)
  );

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    stateN  = state;
    cntN    = cnt;
    grantN  = grantIDX;
    ackN    = '0;
    busReqN = busREQO;
    errN    = 1'b0;
    case (state)
      IDLE: begin
        if (pickValid) begin
          grantN  = pickIdx;
          busReqN = 1'b1;
          stateN  = REQ;
        end
      end
      REQ: begin
        // Abort has priority over a coincident upstream ack.
        if (!winnerReq) begin
          busReqN = 1'b0;
          stateN  = IDLE;
        end else if (busACKI) begin
          ackN[grantIDX] = 1'b1;
          busReqN        = 1'b0;
          cntN           = CNT_W'(HOLDMAX);
          stateN         = WAIT;
        end
      end
      WAIT: begin
        if (!winnerReq) begin
          stateN = IDLE;
        end else if (cnt == '0) begin
          errN   = 1'b1;
          stateN = DROP;
        end else begin
          cntN = cnt - 1'b1;
        end
      end
      DROP: begin
        // Keep the timed-out port out until it lets go of its request.
        if (!winnerReq) stateN = IDLE;
      end
      default: stateN = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= CNT_W'(HOLDMAX);
      grantIDX <= '0;
      ackO     <= '0;
      busREQO  <= 1'b0;
      busyO    <= 1'b0;
      errO     <= 1'b0;
    end else begin
      state    <= stateN;
      cnt      <= cntN;
      grantIDX <= grantN;
      ackO     <= ackN;
      busREQO  <= busReqN;
      busyO    <= (stateN != IDLE);
      errO     <= errN;
    end
  end

endmodule

// File: tb/tb_kmc_npr_arb.sv
// tb_kmc_npr_arb: directed bench for kmc_npr_arb (NREQ=4, HOLDMAX=4).
// Build option: KMCNPRARB_RR_EN switches the expected grant order.
module tb_kmc_npr_arb;

  logic       clk;
  logic       rst;
  logic [3:0] reqI;
  logic [3:0] ackO;
  logic       busREQO;
  logic       busACKI;
  logic [1:0] grantIDX;
  logic       busyO;
  logic       errO;

  int checks   = 0;
  int failures = 0;

  kmc_npr_arb #(
    .NREQ    (4),
    .HOLDMAX (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .reqI     (reqI),
    .ackO     (ackO),
    .busREQO  (busREQO),
    .busACKI  (busACKI),
    .grantIDX (grantIDX),
    .busyO    (busyO),
    .errO     (errO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst     = 1'b1;
    reqI    = '0;
    busACKI = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [3:0] expAck;

  initial begin
    rst     = 1'b1;
    reqI    = '0;
    busACKI = 1'b0;
    #1;
    doReset();

    // Reset state
    checkVal("rst_ack",   ackO,     0);
    checkVal("rst_bus",   busREQO,  0);
    checkVal("rst_grant", grantIDX, 0);
    checkVal("rst_busy",  busyO,    0);
    checkVal("rst_err",   errO,     0);

    // Single request, upstream ack three cycles later
    reqI = 4'b0001;
    tick();
    checkVal("single_bus1",  busREQO,  1);
    checkVal("single_busy1", busyO,    1);
    checkVal("single_grant", grantIDX, 0);
    checkVal("single_noack", ackO,     0);
    tick();
    tick();
    checkVal("single_bus_hold", busREQO, 1);
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    checkVal("single_ack",   ackO,    4'b0001);
    checkVal("single_bus0",  busREQO, 0);
    tick();
    checkVal("single_ack_1cyc", ackO,  0);
    checkVal("single_wait_busy", busyO, 1);
    reqI = 4'b0000;
    tick();
    checkVal("single_idle", busyO, 0);

    // All four requesting; each winner releases two cycles after its ack
    doReset();
    reqI = 4'hF;
    tick();
    for (int k = 0; k < 5; k++) begin
`ifdef KMCNPRARB_RR_EN
      expAck = 4'(1 << (k % 4));
`else
      expAck = 4'b0001;
`endif
      checkVal("rr_bus", busREQO, 1);
      busACKI = 1'b1;
      tick();
      busACKI = 1'b0;
      checkVal("rr_ack", ackO, expAck);
      tick();
      tick();
      reqI = 4'hF & ~expAck;
      tick();
      checkVal("rr_idle", busyO, 0);
      reqI = 4'hF;
      tick();
    end
    reqI = '0;
    tick();
    tick();

    // Abort in REQ: port 2 drops before the upstream ack
    doReset();
    reqI = 4'b0100;
    tick();
    checkVal("abort_grant", grantIDX, 2);
    checkVal("abort_bus1",  busREQO,  1);
    reqI = 4'b0000;
    tick();
    checkVal("abort_bus0",  busREQO, 0);
    checkVal("abort_noack", ackO,    0);
    checkVal("abort_idle",  busyO,   0);
    // Pointer must still be 0: with 2 and 3 requesting, port 2 wins
    reqI = 4'b1100;
    tick();
    checkVal("abort_regrant", grantIDX, 2);
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    checkVal("abort_reack", ackO, 4'b0100);
    reqI = '0;
    tick();
    tick();

    // Abort and upstream ack in the same cycle: abort wins
    reqI = 4'b0010;
    tick();
    checkVal("sim_bus1", busREQO, 1);
    reqI    = 4'b0000;
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    checkVal("sim_noack", ackO,    0);
    checkVal("sim_idle",  busyO,   0);
    checkVal("sim_bus0",  busREQO, 0);

    // Hold timeout: port 0 never releases, port 1 waits
    doReset();
    reqI = 4'b0011;
    tick();
    checkVal("to_grant", grantIDX, 0);
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    checkVal("to_ack", ackO, 4'b0001);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkVal("to_err_early", errO, 0);
    end
    tick();
    checkVal("to_err", errO, 1);
    tick();
    checkVal("to_err_pulse", errO,    0);
    checkVal("to_drop_busy", busyO,   1);
    tick();
    tick();
    checkVal("to_drop_nobus", busREQO, 0);
    checkVal("to_drop_noack", ackO,    0);
    reqI = 4'b0010;
    tick();
    checkVal("to_drop_idle", busyO, 0);
    tick();
    checkVal("to_next_grant", grantIDX, 1);
    checkVal("to_next_bus",   busREQO,  1);
    reqI = '0;
    tick();

    // Reset while in REQ, with a nonzero pointer in round-robin builds
    reqI = 4'b0100;
    tick();
    checkVal("rstreq_bus1", busREQO, 1);
    rst     = 1'b1;
    busACKI = 1'b1;
    tick();
    rst     = 1'b0;
    busACKI = 1'b0;
    checkVal("rstreq_bus0",  busREQO,  0);
    checkVal("rstreq_idle",  busyO,    0);
    checkVal("rstreq_noack", ackO,     0);
    checkVal("rstreq_grant", grantIDX, 0);
    // Pointer back to 0: 0 beats 3 in either mode
    reqI = 4'b1001;
    tick();
    checkVal("rstreq_ptr0", grantIDX, 0);
    reqI = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
